// File: rtl/mdu_defs.sv
`default_nettype none
// ============================================================================
// Module      : mdu_defs (package)
// Description : Shared definitions for the multiply/divide unit: MDOp
//               encodings, FSM state encoding, default latencies and small
//               opcode-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_defs;

    // MDOp encodings; 3'b11x are no-ops.
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int c_DEFAULT_MULT_CYCLES = 5;
    localparam int c_DEFAULT_DIV_CYCLES  = 10;

    // Multiplies and divides occupy the lower half of the opcode space.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_core.sv
`default_nettype none
// ============================================================================
// Module      : md_core
// Description : Combinational arithmetic datapath for the multiply/divide
//               unit. Produces the HI/LO pair for MULT/MULTU/DIV/DIVU and
//               flags a zero divisor on divide opcodes.
// Ports       : MDOp   in  3   operation select
//               A      in  32  rs operand (multiplicand / dividend)
//               B      in  32  rt operand (multiplier / divisor)
//               hi_res out 32  high product word / remainder
//               lo_res out 32  low product word / quotient
//               div0   out 1   divide opcode with B == 0
// Revision    : 1.0 - initial release
// ============================================================================
module md_core
    import mdu_defs::*;
(
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dvsr;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    always_comb begin
        // Low 64 bits of a product are the same whether signed or not, so
        // sign-extending the operands to 64 bits yields the signed product.
        w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        w_prod_u = {32'b0, A} * {32'b0, B};

        // Signed divide is done on magnitudes and the signs reapplied.
        // This keeps 0x80000000 / -1 well defined: the magnitude quotient
        // 0x80000000 negates back to itself, remainder 0.
        w_signed_div = (MDOp == MD_DIV);
        w_abs_a      = (w_signed_div && A[31]) ? (32'd0 - A) : A;
        w_abs_b      = (w_signed_div && B[31]) ? (32'd0 - B) : B;

        // Substitute a divisor of 1 so the divider never sees zero; the
        // result is discarded by the top when div0 is set.
        w_dvsr  = (B == 32'd0) ? 32'd1 : w_abs_b;
        w_q_mag = w_abs_a / w_dvsr;
        w_r_mag = w_abs_a % w_dvsr;

        hi_res = 32'd0;
        lo_res = 32'd0;
        div0   = is_div(MDOp) && (B == 32'd0);

        case (MDOp)
            MD_MULT: begin
                hi_res = w_prod_s[63:32];
                lo_res = w_prod_s[31:0];
            end
            MD_MULTU: begin
                hi_res = w_prod_u[63:32];
                lo_res = w_prod_u[31:0];
            end
            MD_DIV: begin
                lo_res = (A[31] ^ B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
                hi_res = A[31] ? (32'd0 - w_r_mag) : w_r_mag;
            end
            MD_DIVU: begin
                lo_res = w_q_mag;
                hi_res = w_r_mag;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO
//               registers. The result is computed at accept time into
//               pending registers and committed to HI/LO after the
//               configured latency; busy stalls the pipeline meanwhile.
// Ports       : clk      in  1   clock, rising edge
//               reset_n  in  1   asynchronous active-low reset
//               start    in  1   issue MDOp this cycle
//               MDOp     in  3   operation select
//               A, B     in  32  operands
//               cancel   in  1   flush the in-flight / issuing op
//               busy     out 1   op in flight
//               done     out 1   one-cycle pulse when HI/LO are committed
//               HI, LO   out 32  architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = c_DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = c_DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES < 2) ? 1 : $clog2(c_MAX_CYCLES + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_load;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_div0;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_done;

    logic [31:0]          w_core_hi;
    logic [31:0]          w_core_lo;
    logic                 w_core_div0;

    logic                 w_idle_issue;
    logic                 w_accept;
    logic                 w_mthi;
    logic                 w_mtlo;
    logic                 w_finish;

    md_core u_core (
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .hi_res (w_core_hi),
        .lo_res (w_core_lo),
        .div0   (w_core_div0)
    );

    // cancel blocks every kind of issue, including the HI/LO moves.
    assign w_idle_issue = (r_state == S_IDLE) && start && !cancel;
    assign w_accept     = w_idle_issue && is_muldiv(MDOp);
    assign w_mthi       = w_idle_issue && (MDOp == MD_MTHI);
    assign w_mtlo       = w_idle_issue && (MDOp == MD_MTLO);
    assign w_finish     = (r_state == S_RUN) && !cancel && (r_count == c_CNT_W'(1));
    assign w_load       = is_div(MDOp) ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cancel || w_finish) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, pending result and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (w_accept) begin
                r_count     <= w_load;
                r_pend_hi   <= w_core_hi;
                r_pend_lo   <= w_core_lo;
                r_pend_div0 <= w_core_div0;
            end else if (r_state == S_RUN) begin
                if (cancel) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end

            // A zero divisor still runs the full latency and pulses done,
            // but leaves HI/LO untouched.
            if (w_finish && !r_pend_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else begin
                if (w_mthi) begin
                    r_hi <= A;
                end
                if (w_mtlo) begin
                    r_lo <= A;
                end
            end
        end
    end

    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. A behavioural model
//               tracks remaining busy cycles and the expected HI/LO using
//               plain 64-bit arithmetic; a compare process checks every
//               cycle, and directed sequences pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  MDOp = 3'd7;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(
        .MULT_CYCLES (c_MULT),
        .DIV_CYCLES  (c_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (op)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b != 0) r = {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int          m_left;
    logic        m_done;
    logic        m_div0;
    logic [63:0] m_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_div0 <= 1'b0;
            m_res  <= 64'd0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (cancel) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        if (!m_div0) begin
                            m_hi <= m_res[63:32];
                            m_lo <= m_res[31:0];
                        end
                    end
                end
            end else if (start && !cancel) begin
                if (MDOp <= 3'd3) begin
                    m_res  <= ref_result(MDOp, A, B);
                    m_div0 <= (MDOp >= 3'd2) && (B == 32'd0);
                    m_left <= (MDOp >= 3'd2) ? c_DIV : c_MULT;
                end else if (MDOp == 3'd4) begin
                    m_hi <= A;
                end else if (MDOp == 3'd5) begin
                    m_lo <= A;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n);
        int cyc;
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom(); B = $urandom();
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cyc), 32'(n));
        check("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a;
        @(negedge clk);
        start = 1'b0; MDOp = 3'd7;
        check("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, c_MULT);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFFA);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MULT);
        check("multu_HI", HI, 32'hFFFF_FFFE);
        check("multu_LO", LO, 32'h0000_0001);

        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, c_DIV);
        check("div_HI", HI, 32'hFFFF_FFFF);
        check("div_LO", LO, 32'hFFFF_FFFD);

        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        do_op(3'd3, 32'd100, 32'd0, c_DIV);
        check("div0_HI", HI, 32'h11);
        check("div0_LO", LO, 32'h22);

        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, c_DIV);
        check("ovf_HI", HI, 32'h0);
        check("ovf_LO", LO, 32'h8000_0000);

        // Cancel in the third RUN cycle.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd0; A = 32'd7; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_done", {31'd0, done}, 32'd0);
        repeat (8) @(negedge clk);
        check("cancel_HI", HI, 32'h0);
        check("cancel_LO", LO, 32'h8000_0000);

        // cancel coincident with an MTLO issue wins.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd5; A = 32'h33; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_mt_LO", LO, 32'h8000_0000);

        // Asynchronous reset in the fourth RUN cycle of a DIV.
        @(negedge clk);
        start = 1'b1; MDOp = 3'd2; A = 32'd50; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_HI", HI, 32'd0);
        check("arst_LO", LO, 32'd0);
        #1 reset_n = 1'b1;
        mt(3'd5, 32'd5);
        check("post_rst_LO", LO, 32'd5);

        // Randomized traffic, including issues while busy and cancels.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            MDOp   = 3'($urandom_range(0, 7));
            A      = rnd_val();
            B      = rnd_val();
            cancel = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        repeat (c_DIV + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
